ysyx_23060184_ifu: RTL and testbench

//  Instruction fetch unit: owns the PC and fetches one 32-bit instruction at a time from imem.

---
 rtl/ysyx_23060184_ifu_pkg.sv | 13 +
 rtl/ysyx_23060184_ifu_if.sv | 25 ++
 rtl/ysyx_23060184_ifu_perf.sv | 20 ++
 rtl/ysyx_23060184_ifu.sv | 88 ++++++++
 tb/tb_ysyx_23060184_ifu.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_23060184_ifu_pkg.sv
// ysyx_23060184_ifu_pkg: shared IFU constants and FSM state encoding
package ysyx_23060184_ifu_pkg;
  localparam int IFU_DATA_WIDTH = 32;
  localparam int IFU_CNT_WIDTH = 32;
  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_INST_INC = 32'd4;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } ifu_state_e;
endpackage

// File: rtl/ysyx_23060184_ifu_if.sv
// ysyx_23060184_ifu_if: redirect, imem request/response and IDU instruction channels
interface ysyx_23060184_ifu_if import ysyx_23060184_ifu_pkg::*; #(
  parameter int DW = IFU_DATA_WIDTH
);
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [DW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic          imem_resp_ready;
  logic [DW-1:0] imem_resp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst;
  logic [DW-1:0] inst_pc;
  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, imem_resp_ready, inst_valid, inst, inst_pc
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, imem_resp_ready, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/ysyx_23060184_ifu_perf.sv
// ysyx_23060184_ifu_perf: wrapping fetch and stall counters, built only with IFU_PERF_CNT_EN
`ifdef IFU_PERF_CNT_EN
module ysyx_23060184_ifu_perf import ysyx_23060184_ifu_pkg::*; (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     fetch,
  input  logic                     stall,
  output logic [IFU_CNT_WIDTH-1:0] fetch_cnt,
  output logic [IFU_CNT_WIDTH-1:0] stall_cnt
);
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      fetch_cnt <= fetch ? fetch_cnt + 1'b1 : fetch_cnt;
      stall_cnt <= stall ? stall_cnt + 1'b1 : stall_cnt;
    end
endmodule
`endif

// File: rtl/ysyx_23060184_ifu.sv
// ysyx_23060184_ifu: PC owner fetching one instruction at a time from imem and handing it to IDU.
// Defining IFU_PERF_CNT_EN adds the perf_fetch_cnt/perf_stall_cnt counter ports.
module ysyx_23060184_ifu import ysyx_23060184_ifu_pkg::*; #(
  parameter int                    DATA_WIDTH = IFU_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rstn,
  ysyx_23060184_ifu_if.master      bus
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [IFU_CNT_WIDTH-1:0] perf_fetch_cnt,
  output logic [IFU_CNT_WIDTH-1:0] perf_stall_cnt
`endif
);
  ifu_state_e            state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] inst_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;
  logic                  drop;
  logic                  req_hs;
  logic                  resp_hs;
  logic                  inst_hs;
  assign bus.imem_req_valid  = state == S_REQ;
  assign bus.imem_resp_ready = state == S_WAIT;
  assign bus.inst_valid      = state == S_OUT;
  assign bus.imem_req_addr   = pc;
  assign bus.inst            = inst_q;
  assign bus.inst_pc         = inst_pc_q;
  assign req_hs  = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_hs = bus.imem_resp_valid && bus.imem_resp_ready;
  assign inst_hs = bus.inst_valid && bus.inst_ready;
  // drop marks the single outstanding response as stale after a redirect
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_REQ;
          if (bus.redirect_valid) pc <= bus.redirect_pc;
        end
        S_REQ: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (req_hs) begin
            state <= S_WAIT;
            drop  <= bus.redirect_valid;
          end
        end
        S_WAIT: begin
          if (bus.redirect_valid) pc <= bus.redirect_pc;
          if (resp_hs) begin
            drop <= 1'b0;
            if (drop || bus.redirect_valid) state <= S_REQ;
            else begin
              inst_q    <= bus.imem_resp_data;
              inst_pc_q <= pc;
              state     <= S_OUT;
            end
          end else if (bus.redirect_valid) drop <= 1'b1;
        end
        S_OUT: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_pc;
            state <= S_REQ;
          end else if (inst_hs) begin
            pc    <= pc + DATA_WIDTH'(IFU_INST_INC);
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
`ifdef IFU_PERF_CNT_EN
  ysyx_23060184_ifu_perf u_perf (
    .clk       (clk),
    .rstn      (rstn),
    .fetch     (inst_hs),
    .stall     ((bus.inst_valid && !bus.inst_ready) || state == S_REQ || state == S_WAIT),
    .fetch_cnt (perf_fetch_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// tb_ysyx_23060184_ifu: scoreboard bench for the IFU against a behavioural imem with programmable latency
module tb_ysyx_23060184_ifu;
  import ysyx_23060184_ifu_pkg::*;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_ready_en = 1'b1;
  int          resp_delay = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  exp_t        exp_q[$];
  logic [31:0] req_q[$];
  logic        pend;
  logic [31:0] paddr;
  int          dly;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf;
  logic [31:0] ps;
`endif
  always #5 clk = ~clk;
  ysyx_23060184_ifu_if bus ();
  ysyx_23060184_ifu dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (pf),
    .perf_stall_cnt (ps)
`endif
  );
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a == 32'h8000_0200 ? 32'hDEAD_BEEF : a == 32'h8000_000C ? 32'h0000_0013 : a ^ 32'h5A5A_0F0F;
  endfunction
  assign bus.imem_req_ready = req_ready_en;
  // imem: response resp_delay cycles after the accepted request (0 = next cycle)
  always @(posedge clk or negedge rstn)
    if (!rstn) begin
      pend <= 1'b0;
      bus.imem_resp_valid <= 1'b0;
      bus.imem_resp_data <= '0;
      dly <= 0;
    end else begin
      if (bus.imem_resp_valid && bus.imem_resp_ready) bus.imem_resp_valid <= 1'b0;
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (resp_delay == 0) begin
          bus.imem_resp_valid <= 1'b1;
          bus.imem_resp_data <= mem_data(bus.imem_req_addr);
        end else begin
          pend <= 1'b1;
          paddr <= bus.imem_req_addr;
          dly <= resp_delay - 1;
        end
      end else if (pend) begin
        if (dly == 0) begin
          bus.imem_resp_valid <= 1'b1;
          bus.imem_resp_data <= mem_data(paddr);
          pend <= 1'b0;
        end else dly <= dly - 1;
      end
    end
  always @(negedge clk)
    if (rstn) begin : mon
      exp_t e;
      if (bus.imem_req_valid && bus.imem_req_ready) req_q.push_back(bus.imem_req_addr);
      if (bus.inst_valid && bus.inst_ready) begin
        hs_cnt++;
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL inst_unexpected: got pc=%h inst=%h, none expected", bus.inst_pc, bus.inst);
        end else begin
          e = exp_q.pop_front();
          if ({bus.inst_pc, bus.inst} !== {e.pc, e.inst}) begin
            n_fail++;
            $display("FAIL inst_scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h", bus.inst_pc, bus.inst, e.pc, e.inst);
          end
        end
      end
    end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.inst = mem_data(pc);
    exp_q.push_back(e);
  endtask
  task automatic take_n(input int n);
    int tgt = hs_cnt + n;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf0 = pf;
`endif
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 300 && hs_cnt < tgt; i++) cyc();
    bus.inst_ready = 1'b0;
    n_chk++;
    if (hs_cnt < tgt) begin
      n_fail++;
      $display("FAIL take_timeout: got %0d handshakes, expected %0d", hs_cnt, tgt);
    end
`ifdef IFU_PERF_CNT_EN
    n_chk++;
    if (pf - pf0 !== 32'(n)) begin
      n_fail++;
      $display("FAIL perf_fetch: got delta %0d, expected %0d", pf - pf0, n);
    end
`endif
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 100 && !bus.inst_valid; i++) cyc();
    n_chk++;
    if (!bus.inst_valid) begin
      n_fail++;
      $display("FAIL wait_inst_valid: got 0, expected 1 within 100 cycles");
    end
  endtask
  task automatic wait_req(output logic bad);
    bad = 1'b0;
    for (int i = 0; i < 100 && req_q.size() == 0; i++) begin
      cyc();
      if (bus.inst_valid) bad = 1'b1;
    end
    n_chk++;
    if (req_q.size() == 0) begin
      n_fail++;
      $display("FAIL wait_req: got no request, expected one within 100 cycles");
      req_q.push_back('x);
    end
  endtask
  task automatic test_reset();
    rstn = 1'b0;
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) cyc();
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_addr} !==
        {3'b000, 32'h0, 32'h0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b%b%b inst=%h pc=%h addr=%h, expected 000/0/0/80000000",
               bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_addr);
    end
`ifdef IFU_PERF_CNT_EN
    n_chk++;
    if ({pf, ps} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_perf: got %0d/%0d, expected 0/0", pf, ps);
    end
`endif
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL first_req: got valid=%b addr=%h, expected 1/80000000", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask
  task automatic test_fetch();
    for (int i = 0; i < 3; i++) push_exp(32'h8000_0000 + 32'(4 * i));
    take_n(3);
  endtask
  task automatic test_stall();
    logic [31:0] s0;
    wait_valid();
`ifdef IFU_PERF_CNT_EN
    s0 = ps;
`else
    s0 = '0;
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_valid} !== {1'b1, 32'h13, 32'h8000_000C, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b inst=%h pc=%h req=%b, expected 1/00000013/8000000c/0",
                 bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_valid);
      end
    end
    cyc();
`ifdef IFU_PERF_CNT_EN
    n_chk++;
    if (ps - s0 !== 32'd5) begin
      n_fail++;
      $display("FAIL perf_stall: got delta %0d, expected 5", ps - s0);
    end
`endif
    push_exp(32'h8000_000C);
    take_n(1);
  endtask
  task automatic test_redirect_out();
    wait_valid();
    push_exp(32'h8000_0010);
    bus.inst_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0200;
    cyc();
    bus.inst_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8000_0200}) begin
      n_fail++;
      $display("FAIL redirect_out_addr: got valid=%b addr=%h, expected 1/80000200", bus.imem_req_valid, bus.imem_req_addr);
    end
  endtask
  task automatic test_redirect_wait();
    logic bad;
    resp_delay = 4;
    for (int i = 0; i < 50 && !bus.imem_resp_ready; i++) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8000_0100;
    cyc();
    bus.redirect_pc = 32'h8000_0180;
    cyc();
    bus.redirect_valid = 1'b0;
    resp_delay = 0;
    req_q.delete();
    wait_req(bad);
    n_chk++;
    if (req_q[0] !== 32'h8000_0180) begin
      n_fail++;
      $display("FAIL redirect_wait_addr: got %h, expected 80000180", req_q[0]);
    end
    n_chk++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL stale_resp_dropped: got inst_valid=1 inst=%h, expected stale response discarded", bus.inst);
    end
    push_exp(32'h8000_0180);
    take_n(1);
  endtask
  task automatic test_wrap();
    logic bad;
    req_ready_en = 1'b0;
    cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    cyc();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL redirect_req_addr: got valid=%b addr=%h, expected 1/fffffffc", bus.imem_req_valid, bus.imem_req_addr);
    end
    cyc();
    req_ready_en = 1'b1;
    wait_valid();
    push_exp(32'hFFFF_FFFC);
    take_n(1);
    req_q.delete();
    wait_req(bad);
    n_chk++;
    if (req_q[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h, expected 00000000", req_q[0]);
    end
  endtask
  task automatic test_async_reset();
    wait_valid();
    push_exp(32'h0);
    take_n(1);
    resp_delay = 3;
    for (int i = 0; i < 50 && !bus.imem_resp_ready; i++) cyc();
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_addr} !==
        {3'b000, 32'h0, 32'h0, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL async_reset_outputs: got v=%b%b%b inst=%h pc=%h addr=%h, expected 000/0/0/80000000",
               bus.imem_req_valid, bus.imem_resp_ready, bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req_addr);
    end
    resp_delay = 0;
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.imem_req_valid, bus.imem_req_addr} !== {1'b1, 32'h8000_0000}) begin
      n_fail++;
      $display("FAIL restart_req: got valid=%b addr=%h, expected 1/80000000", bus.imem_req_valid, bus.imem_req_addr);
    end
    push_exp(32'h8000_0000);
    take_n(1);
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_out();
    test_redirect_wait();
    test_wrap();
    test_async_reset();
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
